// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store initiator between execute and the
// memory port. Checks op legality and alignment, issues one read or write
// pulse, waits for the matching ok (with a timeout guard) and returns the
// extended load data or store completion over a valid/ready handshake.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        ld_wen,
  output logic        st_wen,
  output logic [31:0] raddr,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic [7:0]  wmask,
  input  logic [31:0] rdata,
  input  logic        rdata_ok,
  input  logic        wdata_ok
);

  // Last counter value of the WAIT window; reaching it without an ok times out.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_store;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;

  logic        w_bad;
  logic        w_ok;
  logic        w_expire;

  // funct3 encodings the unit does not implement for the given direction.
  function automatic logic op_illegal(input logic store, input logic [2:0] op);
    if (store) return !(op inside {3'b000, 3'b001, 3'b010});
    return (op == 3'b011) || (op[2:1] == 2'b11);
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    return ((op[1:0] == 2'b01) && lo[0]) || ((op[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  // Byte lanes touched by the access within the addressed word.
  function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] lo);
    case (op[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Move the addressed lanes down to bit 0 and sign- or zero-extend.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [31:0] s;
    s = word >> {lo, 3'b000};
    case (op)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign w_bad    = op_illegal(req_store, req_op) || misaligned(req_op, req_addr[1:0]);
  assign w_ok     = r_store ? wdata_ok : rdata_ok;
  assign w_expire = (r_cnt == CNT_LAST);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and output decode; every output is forced low while in reset.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_rd    = '0;
    resp_err   = 1'b0;
    ld_wen     = 1'b0;
    st_wen     = 1'b0;
    raddr      = '0;
    waddr      = '0;
    wdata      = '0;
    wmask      = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = reset;
        if (req_valid) w_next = w_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        w_next = S_WAIT;
        if (reset) begin
          ld_wen = !r_store;
          st_wen = r_store;
          raddr  = {r_addr[31:2], 2'b00};
          waddr  = {r_addr[31:2], 2'b00};
          wdata  = r_wdata << {r_addr[1:0], 3'b000};
          wmask  = {4'b0000, lane_mask(r_op, r_addr[1:0])};
        end
      end
      S_WAIT: begin
        if (w_ok || w_expire) w_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) w_next = S_IDLE;
        if (reset) begin
          resp_valid = 1'b1;
          resp_rdata = r_rdata;
          resp_rd    = r_rd;
          resp_err   = r_err;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_store <= 1'b0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store <= req_store;
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rd    <= req_rd;
            r_err   <= w_bad;
            r_rdata <= '0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (w_ok) begin
            r_err <= 1'b0;
            if (!r_store) r_rdata <= load_extract(r_op, r_addr[1:0], rdata);
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed cases, randomized transactions against a
// behavioural model, timeout, back-to-back throughput, hold and mid-flight reset.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        ld_wen;
  logic        st_wen;
  logic [31:0] raddr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [7:0]  wmask;
  logic [31:0] rdata = '0;
  logic        rdata_ok = 1'b0;
  logic        wdata_ok = 1'b0;

  int checks = 0;
  int failures = 0;

  // Observations from the most recent run_txn
  bit          got_ready;
  int          got_en_cnt;
  int          got_en_cycle;
  bit          got_en_ld;
  bit          got_en_st;
  logic [31:0] got_raddr;
  logic [31:0] got_waddr;
  logic [31:0] got_wdata;
  logic [7:0]  got_wmask;
  bit          got_leak;
  int          got_resp_cycle;
  logic [31:0] got_rdata;
  logic [4:0]  got_rd;
  logic        got_err;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .ld_wen     (ld_wen),
    .st_wen     (st_wen),
    .raddr      (raddr),
    .waddr      (waddr),
    .wdata      (wdata),
    .wmask      (wmask),
    .rdata      (rdata),
    .rdata_ok   (rdata_ok),
    .wdata_ok   (wdata_ok)
  );

  always #5 clock = ~clock;

  // Behavioural model: outcome of one transaction from the access rules.
  // delay < 0 means memory never answers; otherwise ok arrives delay cycles
  // after the first WAIT cycle. Cycle numbers count from the accept edge.
  task automatic model(input bit st, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] word, input int delay,
                       output bit e_err, output logic [31:0] e_rdata, output int e_cycle,
                       output bit e_acc, output logic [7:0] e_mask, output logic [31:0] e_wdata);
    int size, off;
    bit sgn, legal;
    longint v;
    off = int'(addr[1:0]);
    case (op)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    legal = st ? (op <= 3'd2) : (size != 0);
    sgn = (op == 3'd0) || (op == 3'd1);
    e_mask = '0;
    e_wdata = '0;
    if (!legal || (off % size) != 0) begin
      e_err = 1'b1; e_rdata = '0; e_cycle = 1; e_acc = 1'b0;
    end else begin
      e_acc = 1'b1;
      e_mask = 8'(((1 << size) - 1) << off);
      e_wdata = 32'(longint'(wd) << (8 * off));
      if (delay < 0 || delay >= TO) begin
        e_err = 1'b1; e_rdata = '0; e_cycle = TO + 2;
      end else begin
        e_err = 1'b0; e_cycle = 3 + delay;
        if (st) e_rdata = '0;
        else begin
          v = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
          if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
          e_rdata = 32'(v);
        end
      end
    end
  endtask

  // Drives one request from IDLE and plays the memory; records what it saw.
  // Entered and left at a falling edge with the DUT idle.
  task automatic run_txn(input bit st, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] word,
                         input int delay, input bit stray);
    bit ok_now;
    got_en_cnt = 0; got_en_cycle = 0; got_en_ld = 0; got_en_st = 0;
    got_raddr = '0; got_waddr = '0; got_wdata = '0; got_wmask = '0; got_leak = 0;
    got_resp_cycle = 0; got_rdata = '0; got_rd = '0; got_err = 1'b0;
    req_valid = 1'b1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
    req_rd = rd; resp_ready = 1'b1; rdata_ok = 1'b0; wdata_ok = 1'b0;
    got_ready = req_ready;
    @(posedge clock);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_op = 3'($urandom); req_rd = 5'($urandom);
      if (ld_wen || st_wen) begin
        got_en_cnt++; got_en_cycle = n; got_en_ld = ld_wen; got_en_st = st_wen;
        got_raddr = raddr; got_waddr = waddr; got_wdata = wdata; got_wmask = wmask;
      end else if ((raddr | waddr | wdata | {24'd0, wmask}) != 32'd0) begin
        got_leak = 1'b1;
      end
      if (resp_valid) begin
        got_resp_cycle = n; got_rdata = resp_rdata; got_rd = resp_rd; got_err = resp_err;
        rdata_ok = 1'b0; wdata_ok = 1'b0;
        break;
      end
      ok_now = (delay >= 0) && (got_en_cycle > 0) && (n == got_en_cycle + 1 + delay);
      rdata = ok_now ? word : $urandom;
      rdata_ok = ok_now && !st;
      wdata_ok = ok_now && st;
      if (stray) begin
        if (st) rdata_ok = 1'($urandom);
        else    wdata_ok = 1'($urandom);
      end
    end
    @(posedge clock);
    @(negedge clock);
    rdata_ok = 1'b0; wdata_ok = 1'b0;
  endtask

  task automatic test_reset;
    logic [145:0] outs;
    req_valid = 1'b1; req_addr = 32'h8000_0010; rdata_ok = 1'b1; wdata_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      outs = {req_ready, resp_valid, ld_wen, st_wen, raddr, waddr, wdata, wmask,
              resp_rdata, resp_rd, resp_err};
      checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    end
    reset = 1'b1; req_valid = 1'b0; rdata_ok = 1'b0; wdata_ok = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
  endtask

  task automatic test_directed;
    run_txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd1, 32'hDEAD_BEEF, 0, 1'b0);
    checks++; if (got_raddr !== 32'h8000_0010) begin failures++; $display("FAIL lw_raddr got=%h exp=80000010", got_raddr); end
    checks++; if (got_en_cnt !== 1 || got_en_ld !== 1'b1) begin failures++; $display("FAIL lw_ld_wen got=%0d exp=1", got_en_cnt); end
    checks++; if (got_resp_cycle !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", got_resp_cycle); end
    checks++; if (got_rdata !== 32'hDEAD_BEEF || got_err !== 1'b0) begin failures++; $display("FAIL lw_rdata got=%h/%b exp=deadbeef/0", got_rdata, got_err); end
    checks++; if (got_rd !== 5'd1) begin failures++; $display("FAIL lw_rd got=%0d exp=1", got_rd); end

    run_txn(1'b0, 3'b000, 32'h8000_0013, 32'h0, 5'd2, 32'h80FF_0000, 0, 1'b0);
    checks++; if (got_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", got_rdata); end
    run_txn(1'b0, 3'b100, 32'h8000_0013, 32'h0, 5'd3, 32'h80FF_0000, 0, 1'b0);
    checks++; if (got_rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", got_rdata); end

    run_txn(1'b1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 5'd4, 32'h0, 0, 1'b0);
    checks++; if (got_waddr !== 32'h8000_0004) begin failures++; $display("FAIL sh_waddr got=%h exp=80000004", got_waddr); end
    checks++; if (got_wmask !== 8'h0C) begin failures++; $display("FAIL sh_wmask got=%h exp=0c", got_wmask); end
    checks++; if (got_wdata !== 32'hABCD_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd0000", got_wdata); end
    checks++; if (got_en_cnt !== 1 || got_en_st !== 1'b1) begin failures++; $display("FAIL sh_st_wen got=%0d exp=1", got_en_cnt); end
    checks++; if (got_err !== 1'b0 || got_rdata !== 32'h0) begin failures++; $display("FAIL sh_resp got=%h/%b exp=0/0", got_rdata, got_err); end

    run_txn(1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd5, 32'h1111_1111, 0, 1'b0);
    checks++; if (got_resp_cycle !== 1 || got_err !== 1'b1) begin failures++; $display("FAIL misalign_resp got=%0d/%b exp=1/1", got_resp_cycle, got_err); end
    checks++; if (got_en_cnt !== 0) begin failures++; $display("FAIL misalign_no_access got=%0d exp=0", got_en_cnt); end
    checks++; if (got_rdata !== 32'h0) begin failures++; $display("FAIL misalign_rdata got=%h exp=0", got_rdata); end
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 3'b010, 32'h8000_0040, 32'h0, 5'd6, 32'h5555_5555, -1, 1'b0);
    checks++; if (got_resp_cycle !== TO + 2) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", got_resp_cycle, TO + 2); end
    checks++; if (got_err !== 1'b1 || got_rdata !== 32'h0) begin failures++; $display("FAIL timeout_resp got=%h/%b exp=0/1", got_rdata, got_err); end
    // Late ok while idle must be ignored
    rdata_ok = 1'b1; rdata = 32'h5555_5555;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL late_ok_ignored got=%b%b exp=01", resp_valid, req_ready); end
    end
    rdata_ok = 1'b0;
    run_txn(1'b0, 3'b101, 32'h8000_0042, 32'h0, 5'd7, 32'h9876_0000, 1, 1'b0);
    checks++; if (got_rdata !== 32'h0000_9876 || got_err !== 1'b0) begin failures++; $display("FAIL after_timeout got=%h/%b exp=00009876/0", got_rdata, got_err); end
    checks++; if (got_resp_cycle !== 4) begin failures++; $display("FAIL after_timeout_lat got=%0d exp=4", got_resp_cycle); end
    // ok on the last allowed WAIT cycle still wins over the timeout
    run_txn(1'b1, 3'b000, 32'h8000_0041, 32'h0000_00A5, 5'd8, 32'h0, TO - 1, 1'b0);
    checks++; if (got_err !== 1'b0 || got_resp_cycle !== TO + 2) begin failures++; $display("FAIL last_cycle_ok got=%0d/%b exp=%0d/0", got_resp_cycle, got_err, TO + 2); end
  endtask

  task automatic test_random;
    bit st, stray, e_err, e_acc;
    logic [2:0] op;
    logic [31:0] a, wd, word, e_rdata, e_wdata;
    logic [4:0] rd;
    logic [7:0] e_mask;
    int d, e_cycle;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom); op = 3'($urandom_range(0, 7)); a = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (op[1:0] == 2'b01) a[0] = 1'b0;
        else if (op[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      wd = $urandom; word = $urandom; rd = 5'($urandom);
      d = int'($urandom_range(0, 7)) - 1; stray = 1'($urandom);
      model(st, op, a, wd, word, d, e_err, e_rdata, e_cycle, e_acc, e_mask, e_wdata);
      run_txn(st, op, a, wd, rd, word, d, stray);
      checks++; if (got_ready !== 1'b1) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=1", i, got_ready); end
      checks++; if (got_resp_cycle !== e_cycle) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, got_resp_cycle, e_cycle); end
      checks++; if (got_err !== e_err) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", i, got_err, e_err); end
      checks++; if (got_rdata !== e_rdata) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, got_rdata, e_rdata); end
      checks++; if (got_rd !== rd) begin failures++; $display("FAIL rnd%0d_rd got=%0d exp=%0d", i, got_rd, rd); end
      checks++; if (got_en_cnt !== (e_acc ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_en_count got=%0d exp=%0d", i, got_en_cnt, e_acc); end
      checks++; if (got_leak !== 1'b0) begin failures++; $display("FAIL rnd%0d_mem_idle got=%b exp=0", i, got_leak); end
      if (e_acc) begin
        checks++; if (got_en_st !== st || got_en_ld !== !st) begin failures++; $display("FAIL rnd%0d_en_kind got=%b%b exp=%b%b", i, got_en_ld, got_en_st, !st, st); end
        checks++; if (got_raddr !== (a & 32'hFFFF_FFFC) || got_waddr !== (a & 32'hFFFF_FFFC)) begin failures++; $display("FAIL rnd%0d_addr got=%h/%h exp=%h", i, got_raddr, got_waddr, a & 32'hFFFF_FFFC); end
        if (st) begin
          checks++; if (got_wmask !== e_mask) begin failures++; $display("FAIL rnd%0d_wmask got=%h exp=%h", i, got_wmask, e_mask); end
          checks++; if (got_wdata !== e_wdata) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, got_wdata, e_wdata); end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int low;
    bit prev_en;
    low = 0; prev_en = 1'b0;
    req_store = 1'b0; req_op = 3'b010; req_rd = 5'd3; resp_ready = 1'b1;
    for (int c = 0; c < 23; c++) begin
      req_valid = (c < 17);
      req_addr = $urandom & 32'hFFFF_FFFC;
      if (c < 17) begin
        if (req_ready) acc.push_back(c);
        else low++;
      end
      rdata_ok = prev_en; rdata = $urandom;
      prev_en = ld_wen;
      @(posedge clock);
      @(negedge clock);
    end
    req_valid = 1'b0; rdata_ok = 1'b0;
    checks++; if (acc.size() !== 5) begin failures++; $display("FAIL b2b_accepts got=%0d exp=5", acc.size()); end
    for (int i = 0; i < acc.size(); i++) begin
      checks++; if (acc[i] !== 4 * i) begin failures++; $display("FAIL b2b_accept_cycle%0d got=%0d exp=%0d", i, acc[i], 4 * i); end
    end
    checks++; if (low !== 12) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=12", low); end
  endtask

  task automatic test_hold_and_reset;
    logic [31:0] word;
    logic [145:0] outs;
    word = $urandom;
    req_valid = 1'b1; req_store = 1'b0; req_op = 3'b010; req_addr = 32'h8000_0020;
    req_rd = 5'd7; resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_addr = 32'h8000_0024; req_rd = 5'd9;
    checks++; if (ld_wen !== 1'b1 || raddr !== 32'h8000_0020) begin failures++; $display("FAIL hold_issue got=%b/%h exp=1/80000020", ld_wen, raddr); end
    @(posedge clock);
    @(negedge clock);
    rdata = word; rdata_ok = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rdata_ok = 1'b0; rdata = $urandom;
    for (int k = 0; k < 5; k++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== word || resp_rd !== 5'd7 || resp_err !== 1'b0)
        begin failures++; $display("FAIL hold_resp%0d got=%b/%h/%0d/%b exp=1/%h/7/0", k, resp_valid, resp_rdata, resp_rd, resp_err, word); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL hold_ready%0d got=%b exp=0", k, req_ready); end
      if (k == 4) resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b%b exp=10", req_ready, resp_valid); end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++; if (ld_wen !== 1'b1 || raddr !== 32'h8000_0024) begin failures++; $display("FAIL second_issue got=%b/%h exp=1/80000024", ld_wen, raddr); end
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      outs = {req_ready, resp_valid, ld_wen, st_wen, raddr, waddr, wdata, wmask,
              resp_rdata, resp_rd, resp_err};
      checks++; if (outs !== '0) begin failures++; $display("FAIL midreset_outputs%0d got=%h exp=0", c, outs); end
      if (c < 2) begin
        @(posedge clock);
        @(negedge clock);
      end
    end
    reset = 1'b1; rdata_ok = 1'b1; wdata_ok = 1'b1; rdata = $urandom;
    @(posedge clock);
    @(negedge clock);
    rdata_ok = 1'b0; wdata_ok = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ld_wen !== 1'b0) begin failures++; $display("FAIL post_reset got=%b%b%b exp=100", req_ready, resp_valid, ld_wen); end
    @(posedge clock);
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_quiet got=%b%b exp=01", resp_valid, req_ready); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_back_to_back();
    test_hold_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator that sits between the execute stage and the DPI-backed memory port. It accepts one load or store request at a time and checks its alignment. It builds the word address, byte mask and lane-shifted write data, pulses the memory port's read or write enable, and waits for the matching `ok`. It then returns sign- or zero-extended load data, or a store completion, to writeback over a valid/ready handshake, with a timeout guard.

## Interface
- `TIMEOUT`, default 255: number of WAIT cycles without an `ok` before an error response is returned. Legal range is 1..255.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_op`  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_rd`  in  5  destination register tag, echoed on the response.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  writeback accepts the response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_rd`  out  5  echoed tag.
- `resp_err`  out  1  misaligned access, illegal op, or timeout.
- `ld_wen`  out  1  one-cycle read pulse to the memory port.
- `st_wen`  out  1  one-cycle write pulse to the memory port.
- `raddr`  out  32  word-aligned read address.
- `waddr`  out  32  word-aligned write address.
- `wdata`  out  32  lane-shifted write data.
- `wmask`  out  8  byte mask; bits [7:4] are always 0.
- `rdata`  in  32  read word, valid while `rdata_ok` is high.
- `rdata_ok`  in  1  read complete.
- `wdata_ok`  in  1  write complete.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On accept, latch store flag, op, address, data and tag.
  - If the op is illegal or the access is misaligned, go to RESP with `err` = 1. No memory access is made.
  - Otherwise go to ISSUE.
- Illegal ops:
  - Loads: funct3 011, 110, 111.
  - Stores: any funct3 other than 000, 001, 010.
- Misaligned:
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` ≠ 0.
- ISSUE:
  - Assert `ld_wen` or `st_wen` for exactly this one cycle, then go to WAIT.
  - Clear the timeout counter (8-bit).
- WAIT:
  - Load: `rdata_ok` = 1 → capture the extracted data → RESP with `err` = 0.
  - Store: `wdata_ok` = 1 → RESP with `err` = 0.
  - The wrong-type `ok` (e.g. `wdata_ok` during a load) is ignored.
  - Counter reaches `TIMEOUT`-1 with no `ok` → RESP with `err` = 1 and `rdata` = 0.
- RESP:
  - `resp_valid` = 1; all `resp_*` outputs are held stable.
  - Go to IDLE on `resp_ready`.
- Address and data formation:
  - `raddr` = `waddr` = {`addr[31:2]`, 2'b00}.
  - `wdata` = `req_wdata` << (8·`addr[1:0]`).
  - `wmask`: B = 1 << `addr[1:0]`; H = 3 << `addr[1:0]`; W = 0xF.
- Load extraction:
  - Shift `rdata` right by 8·`addr[1:0]`.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Memory-side outputs are 0 outside ISSUE: `ld_wen`, `st_wen`, `wmask`, `wdata`, `raddr`, `waddr`.
- Any `ok` arriving in IDLE, ISSUE or RESP (stale or late) is ignored.

## Timing
- Reset (`reset` = 0 at a clock edge):
  - State → IDLE; counter cleared; latched fields cleared.
  - While `reset` = 0: `req_ready` = 0, `resp_valid` = 0, `ld_wen` = `st_wen` = 0, and all data outputs = 0.
- Reset mid-operation: the transaction is abandoned with no response. An `ok` arriving after reset is ignored.
- Request accepted at edge T:
  - ISSUE during cycle T+1, enable high.
  - Memory returns `ok` during T+2.
  - `resp_valid` = 1 from T+3.
- Error response without memory access: `resp_valid` from T+1.
- Timeout: `resp_valid` on the cycle after the `TIMEOUT`-th WAIT cycle.
- Back-to-back throughput:
  - `resp_ready` is tied to 1: one request per 4 cycles.
  - `req_ready` is low from the cycle after accept until the state returns to IDLE.
- `req_ready` is purely state-decoded. It has no combinational path from `resp_ready`.

## Test plan
- LW at 0x8000_0010 with the memory model returning 0xDEAD_BEEF → `raddr` = 0x8000_0010, `ld_wen` high 1 cycle, `resp_rdata` = 0xDEAD_BEEF at T+3, `err` = 0.
- LB at 0x8000_0013, then LBU at the same address, with `rdata` = 0x80FF_0000 → `resp_rdata` = 0xFFFF_FF80, then 0x0000_0080.
- SH at 0x8000_0006 with `wdata` 0x1234_ABCD → `waddr` = 0x8000_0004, `wmask` = 0x0C, `wdata` = 0xABCD_0000, `st_wen` high 1 cycle, response `err` = 0 with `rdata` = 0.
- LW at 0x8000_0002 → `resp_valid` at T+1 with `err` = 1. `ld_wen` never asserts.
- Load where the model withholds `rdata_ok`, with `TIMEOUT` = 4 → `err` = 1 after 4 WAIT cycles. A later `rdata_ok` is ignored and the next request completes normally.
- Hold `resp_ready` = 0 for 5 cycles while offering a second request, then assert `reset` = 0 during WAIT of that second transaction:
  - The first response is held stable and the second request is not accepted while `resp_ready` = 0.
  - After reset, all outputs are 0 and `req_ready` returns to 1 one cycle after reset is released.
